// File: rtl/bcd_bin.sv
// Packed-BCD to unsigned binary converter, one reverse double-dabble step per
// clock. Operand handshake in, result handshake out; invalid nibbles flag out_err.
module bcd_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BIN_W-1:0]   r_out_bin;
    logic               r_out_err;

    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BIN_W-1:0]   w_bin_next;

    // True when any nibble of the operand is outside 0..9.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
        logic e;
        e = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                e = 1'b1;
            end else begin
                e = e;
            end
        end
        return e;
    endfunction

    // One reverse double-dabble step: shift right, then correct digits >= 8.
    always_comb begin
        w_bin_next  = {r_bcd[0], r_bin[BIN_W-1:1]};
        w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};
        w_bcd_next  = w_bcd_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd_shift[4*d +: 4] >= 4'd8) begin
                w_bcd_next[4*d +: 4] = w_bcd_shift[4*d +: 4] - 4'd3;
            end else begin
                w_bcd_next[4*d +: 4] = w_bcd_shift[4*d +: 4];
            end
        end
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_bcd       <= {BCD_W{1'b0}};
            r_bin       <= {BIN_W{1'b0}};
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bin   <= {BIN_W{1'b0}};
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bcd      <= in_bcd;
                        r_bin      <= {BIN_W{1'b0}};
                        r_cnt      <= CNT_W'(BIN_W);
                        r_err      <= bcd_invalid(in_bcd);
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                BUSY: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last step: publish the result computed this very edge.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_bin   <= r_err ? {BIN_W{1'b0}} : w_bin_next;
                        r_out_err   <= r_err;
                    end else begin
                        r_state     <= BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_out_bin   <= {BIN_W{1'b0}};
                        r_out_err   <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state     <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= {CNT_W{1'b0}};
                    r_err       <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_bin   <= {BIN_W{1'b0}};
                    r_out_err   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_bcd_bin.sv
// Directed self-checking bench for bcd_bin (DIGITS=4, BIN_W=14).
module tb_bcd_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    bcd_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand for a single edge once in_ready is high.
    task automatic accept(input string tag, input logic [15:0] v);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_accepted"}, 32'(in_ready), 32'd0);
    endtask

    // Called #1 after the acceptance edge; expects out_valid after exactly 14 edges.
    task automatic wait_result(input string tag, input logic [13:0] eb, input logic ee);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd14);
        check({tag, "_bin"}, 32'(out_bin), 32'(eb));
        check({tag, "_err"}, 32'(out_err), 32'(ee));
    endtask

    task automatic handshake(input string tag);
        check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_exit_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_exit_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = 16'h0000;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero, with out_ready held high throughout: ignored until DONE.
        out_ready = 1'b1;
        accept("zero", 16'h0000);
        wait_result("zero", 14'd0, 1'b0);
        @(posedge clk); #1;
        check("zero_exit_valid", 32'(out_valid), 32'd0);
        check("zero_exit_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        accept("max", 16'h9999);
        wait_result("max", 14'h270F, 1'b0);
        handshake("max");

        // Backpressure: result must hold for 5 cycles.
        accept("bp", 16'h1234);
        wait_result("bp", 14'h04D2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bin", 32'(out_bin), 32'h04D2);
        end
        handshake("bp");

        accept("err", 16'h12A4);
        wait_result("err", 14'd0, 1'b1);
        handshake("err");

        accept("k8", 16'h8000);
        wait_result("k8", 14'h1F40, 1'b0);
        handshake("k8");

        // in_valid held high; operand changes while BUSY must be ignored.
        in_valid = 1'b1;
        in_bcd   = 16'h0001;
        @(posedge clk); #1;
        in_bcd = 16'h0002;
        check("ovl_busy_rdy", 32'(in_ready), 32'd0);
        wait_result("ovl1", 14'd1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ovl_exit_valid", 32'(out_valid), 32'd0);
        check("ovl_exit_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ovl2_accepted", 32'(in_ready), 32'd0);
        wait_result("ovl2", 14'd2, 1'b0);
        handshake("ovl2");

        // Reset during BUSY aborts the conversion.
        accept("abort", 16'h5678);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd1);
        check("abort_bin", 32'(out_bin), 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // Acceptance on the first edge after reset release.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bcd   = 16'h0042;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_edge_accepted", 32'(in_ready), 32'd0);
        wait_result("first_edge", 14'd42, 1'b0);
        handshake("first_edge");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_bin.md
BCD_BIN -- requirements
Module: bcd_bin

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of packed BCD digits at the input (1..9).
REQ-002 The block SHALL have parameter BIN_W, default 14: binary output width, legal only if 2^BIN_W >= 10^DIGITS.
REQ-003 The block SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1: in_bcd is valid.
REQ-006 The block SHALL have port in_ready  output  1: the block accepts a new operand.
REQ-007 The block SHALL have port in_bcd  input  4*DIGITS: packed BCD, digit 0 in bits [3:0].
REQ-008 The block SHALL have port out_valid  output  1: out_bin and out_err are valid.
REQ-009 The block SHALL have port out_ready  input  1: downstream accepts the result.
REQ-010 The block SHALL have port out_bin  output  BIN_W: unsigned binary value of the accepted operand.
REQ-011 The block SHALL have port out_err  output  1: the accepted operand held at least one nibble greater than 9.

Function
REQ-012 The block SHALL use the FSM states IDLE, BUSY and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE), both registered-state decodes.
REQ-013 Input acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; that edge loads the shift register {bcd=in_bcd, bin=0}, loads iteration counter = BIN_W, latches err = OR over digits of (digit>9), and moves to BUSY.
REQ-014 In IDLE with in_valid=0, the block SHALL hold all state.
REQ-015 Each BUSY edge SHALL perform one reverse double-dabble step: shift {bcd,bin} right by 1 (bcd LSB into bin MSB), then subtract 3 from every bcd digit whose shifted value is >= 8, then decrement the counter.
REQ-016 The edge on which the counter decrements to 0 SHALL transition to DONE.
REQ-017 out_valid SHALL rise exactly BIN_W cycles after the acceptance edge.
REQ-018 In DONE, out_bin SHALL equal the bin register, or 0 when err=1, and out_err SHALL equal err.
REQ-019 out_valid, out_bin and out_err SHALL stay stable in DONE until the edge with out_ready=1, which returns the FSM to IDLE.
REQ-020 A new operand SHALL NOT be accepted on the DONE-exit edge; in_ready first rises in the following cycle.
REQ-021 in_valid and in_bcd SHALL be ignored in BUSY and DONE; no overlap or queueing of operands.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 The arithmetic SHALL be unsigned only; for valid BCD inputs the result is exact, with maximum 10^DIGITS-1 and no overflow when REQ-002 holds.
REQ-024 When err=1, the iteration SHALL still run its full BIN_W cycles, so latency is independent of data.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force state=IDLE, counter=0, shift register=0 and err=0, giving outputs in_ready=1, out_valid=0, out_bin=0 and out_err=0.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the conversion and discard the result, with no out_valid pulse after release.
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-028 The bench SHALL cover: in_bcd=16'h0000 accepted -> after 14 cycles out_valid=1, out_bin=0, out_err=0.
REQ-029 The bench SHALL cover: in_bcd=16'h9999 -> out_bin=14'd9999 (0x270F), out_err=0, with out_valid exactly 14 cycles after acceptance.
REQ-030 The bench SHALL cover: in_bcd=16'h1234 with out_ready held low 5 cycles after out_valid -> out_bin=0x04D2 stable all 5 cycles; after the handshake edge out_valid=0, and in_ready=1 the next cycle.
REQ-031 The bench SHALL cover: in_bcd=16'h12A4 -> out_err=1, out_bin=0, with the same 14-cycle latency.
REQ-032 The bench SHALL cover: in_valid held high with 16'h0001 then 16'h0002 during BUSY -> only the first is converted (out_bin=1) and the second is accepted only once in_ready=1 again.
REQ-033 The bench SHALL cover: rst_n pulsed low mid-BUSY (cycle 7) -> out_valid=0 and in_ready=1 immediately, and no result appears afterwards.
